// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and its hazard/sequencing controller.
// ihit/dhit are single-cycle completion strobes; a pending memory op waits until dhit.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dREN_m;
    logic             dWEN_m;
    logic             halt_m;
    logic             pcsrc_m;
    logic             memtoreg_e;
    logic [REG_W-1:0] rd_e;
    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic             uses_rt_d;

    logic             pc_en;
    logic             en_if_id;
    logic             en_id_ex;
    logic             en_ex_mem;
    logic             en_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       fsm_state;

    modport master (
        input  ihit, dhit, dREN_m, dWEN_m, halt_m, pcsrc_m, memtoreg_e,
               rd_e, rs_d, rt_d, uses_rt_d,
        output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, halt, stall_cnt, fsm_state
    );

    modport slave (
        output ihit, dhit, dREN_m, dWEN_m, halt_m, pcsrc_m, memtoreg_e,
               rd_e, rs_d, rt_d, uses_rt_d,
        input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, halt, stall_cnt, fsm_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for a 5-stage pipeline: latch enables/flushes, PC enable,
// memory waits, load-use stalls, MEM-resolved control flushes, halt, stall counter.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input logic                   CLK,
    input logic                   nRST,
    pipeline_hazard_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             memreq, loaduse, adv;
    logic             pc_en_c, en_if_id_c, en_id_ex_c, en_ex_mem_c, en_mem_wb_c;
    logic             flush_if_id_c, flush_id_ex_c, flush_ex_mem_c;

    assign memreq  = bus.dREN_m | bus.dWEN_m;
    assign loaduse = bus.memtoreg_e && (bus.rd_e != {REG_W{1'b0}}) &&
                     ((bus.rd_e == bus.rs_d) || (bus.uses_rt_d && (bus.rd_e == bus.rt_d)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        adv            = 1'b0;
        pc_en_c        = 1'b0;
        en_if_id_c     = 1'b0;
        en_id_ex_c     = 1'b0;
        en_ex_mem_c    = 1'b0;
        en_mem_wb_c    = 1'b0;
        flush_if_id_c  = 1'b0;
        flush_id_ex_c  = 1'b0;
        flush_ex_mem_c = 1'b0;

        case (state)
            RUN: begin
                if (memreq && !bus.dhit) begin
                    next_state = MEMWAIT;
                end else begin
                    adv = bus.ihit | (memreq & bus.dhit);
                end
            end
            MEMWAIT: begin
                if (bus.dhit) begin
                    adv        = 1'b1;
                    next_state = RUN;
                end
            end
            default: ;
        endcase

        // Priority: halt, then MEM-resolved redirect, then load-use, then fetch miss.
        if (adv) begin
            en_if_id_c  = 1'b1;
            en_id_ex_c  = 1'b1;
            en_ex_mem_c = 1'b1;
            en_mem_wb_c = 1'b1;
            if (bus.halt_m) begin
                flush_if_id_c  = 1'b1;
                flush_id_ex_c  = 1'b1;
                flush_ex_mem_c = 1'b1;
                next_state     = HALT;
            end else if (bus.pcsrc_m) begin
                pc_en_c        = 1'b1;
                flush_if_id_c  = 1'b1;
                flush_id_ex_c  = 1'b1;
                flush_ex_mem_c = 1'b1;
            end else if (loaduse) begin
                en_if_id_c    = 1'b0;
                flush_id_ex_c = 1'b1;
            end else if (!bus.ihit) begin
                flush_if_id_c = 1'b1;
            end else begin
                pc_en_c = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (!pc_en_c && (state != HALT) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.pc_en        = pc_en_c        & nRST;
    assign bus.en_if_id     = en_if_id_c     & nRST;
    assign bus.en_id_ex     = en_id_ex_c     & nRST;
    assign bus.en_ex_mem    = en_ex_mem_c    & nRST;
    assign bus.en_mem_wb    = en_mem_wb_c    & nRST;
    assign bus.flush_if_id  = flush_if_id_c  & nRST;
    assign bus.flush_id_ex  = flush_id_ex_c  & nRST;
    assign bus.flush_ex_mem = flush_ex_mem_c & nRST;
    assign bus.halt         = (state == HALT);
    assign bus.stall_cnt    = cnt;
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: fixed vector table, corner-case sequences and a
// random run against a rule-level model; a CNT_W=4 copy checks counter saturation.
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic       ihit, dhit, dREN_m, dWEN_m, halt_m, pcsrc_m, memtoreg_e;
        logic [4:0] rd_e, rs_d, rt_d;
        logic       uses_rt_d;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    // Output vector order: {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_NORMAL = 8'b1111_1000;
    localparam logic [7:0] O_DONLY  = 8'b0111_1100;
    localparam logic [7:0] O_LUSE   = 8'b0011_1010;
    localparam logic [7:0] O_BRANCH = 8'b1111_1111;
    localparam logic [7:0] O_HALT   = 8'b0111_1111;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    stim_t cur = '0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    m_wait = 0, m_halt = 0;
    int    m_cnt = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();
    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  bus4 ();

    assign bus.ihit = cur.ihit;             assign bus4.ihit = cur.ihit;
    assign bus.dhit = cur.dhit;             assign bus4.dhit = cur.dhit;
    assign bus.dREN_m = cur.dREN_m;         assign bus4.dREN_m = cur.dREN_m;
    assign bus.dWEN_m = cur.dWEN_m;         assign bus4.dWEN_m = cur.dWEN_m;
    assign bus.halt_m = cur.halt_m;         assign bus4.halt_m = cur.halt_m;
    assign bus.pcsrc_m = cur.pcsrc_m;       assign bus4.pcsrc_m = cur.pcsrc_m;
    assign bus.memtoreg_e = cur.memtoreg_e; assign bus4.memtoreg_e = cur.memtoreg_e;
    assign bus.rd_e = cur.rd_e;             assign bus4.rd_e = cur.rd_e;
    assign bus.rs_d = cur.rs_d;             assign bus4.rs_d = cur.rs_d;
    assign bus.rt_d = cur.rt_d;             assign bus4.rt_d = cur.rt_d;
    assign bus.uses_rt_d = cur.uses_rt_d;   assign bus4.uses_rt_d = cur.uses_rt_d;

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut  (.CLK(CLK), .nRST(nRST), .bus(bus));
    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4))  dut4 (.CLK(CLK), .nRST(nRST), .bus(bus4));

    function automatic stim_t mk(input logic ih, dh, rd, wr, hm, pc, mt,
                                 input logic [4:0] rde, rs, rt, input logic urt);
        stim_t s;
        s = '{ih, dh, rd, wr, hm, pc, mt, rde, rs, rt, urt};
        return s;
    endfunction

    // Rule-level reference: returns expected outputs and the next wait/halt flags.
    function automatic logic [7:0] model(input stim_t s, input bit waiting, input bit halted,
                                         output bit nwait, output bit nhalt);
        bit mem, lu, go;
        mem   = s.dREN_m || s.dWEN_m;
        lu    = s.memtoreg_e && (s.rd_e != 0) &&
                ((s.rd_e == s.rs_d) || (s.uses_rt_d && (s.rd_e == s.rt_d)));
        nwait = 0;
        nhalt = halted;
        if (halted) return O_NONE;
        if ((waiting || mem) && !s.dhit) begin
            nwait = waiting || mem;
            if (waiting || mem) return O_NONE;
        end
        go = waiting || s.ihit || mem;
        if (!go) return O_NONE;
        if (s.halt_m) begin
            nhalt = 1;
            return O_HALT;
        end
        if (s.pcsrc_m) return O_BRANCH;
        if (lu) return O_LUSE;
        if (!s.ihit) return O_DONLY;
        return O_NORMAL;
    endfunction

    function automatic logic [7:0] obs();
        return {bus.pc_en, bus.en_if_id, bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb,
                bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Called just after a rising edge; consumes exactly one rising edge.
    task automatic step(input stim_t s, output logic [7:0] got);
        logic [7:0] exp;
        bit nw, nh;
        cur = s;
        @(negedge CLK);
        exp = model(s, m_wait, m_halt, nw, nh);
        got = obs();
        check("outputs", {24'd0, got}, {24'd0, exp});
        check("halt", {31'd0, bus.halt}, {31'd0, m_halt});
        check("stall_cnt", bus.stall_cnt, m_cnt);
        check("stall_cnt4", {28'd0, bus4.stall_cnt}, (m_cnt > 15) ? 32'd15 : m_cnt);
        @(posedge CLK);
        if (!m_halt && !exp[7]) m_cnt++;
        m_wait = nw;
        m_halt = nh;
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #1 nRST = 1'b0;
        #1;
        check("rst_outputs", {24'd0, obs()}, 32'd0);
        check("rst_cnt", bus.stall_cnt, 32'd0);
        check("rst_cnt4", {28'd0, bus4.stall_cnt}, 32'd0);
        check("rst_halt", {31'd0, bus.halt}, 32'd0);
        check("rst_state_run", {30'd0, bus.fsm_state}, 32'd0);
        #1 nRST = 1'b1;
        m_wait = 0;
        m_halt = 0;
        m_cnt  = 0;
    endtask

    vec_t       tbl[12];
    logic [7:0] got;
    stim_t      s;
    int         c0;

    initial begin
        tbl[0]  = '{mk(1,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0), O_NORMAL};
        tbl[1]  = '{mk(0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0), O_NONE};
        tbl[2]  = '{mk(1,1,1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0), O_NORMAL};
        tbl[3]  = '{mk(0,1,0,1,0,0,0, 5'd0, 5'd0, 5'd0, 0), O_DONLY};
        tbl[4]  = '{mk(1,0,0,0,0,0,1, 5'd8, 5'd8, 5'd0, 0), O_LUSE};
        tbl[5]  = '{mk(1,0,0,0,0,0,1, 5'd0, 5'd0, 5'd0, 1), O_NORMAL};
        tbl[6]  = '{mk(1,0,0,0,0,0,1, 5'd9, 5'd3, 5'd9, 1), O_LUSE};
        tbl[7]  = '{mk(1,0,0,0,0,0,1, 5'd9, 5'd3, 5'd9, 0), O_NORMAL};
        tbl[8]  = '{mk(1,0,0,0,0,1,1, 5'd8, 5'd8, 5'd0, 0), O_BRANCH};
        tbl[9]  = '{mk(0,0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0), O_NONE};
        tbl[10] = '{mk(1,0,0,0,0,0,0, 5'd8, 5'd8, 5'd8, 1), O_NORMAL};
        tbl[11] = '{mk(0,0,0,0,0,0,1, 5'd8, 5'd8, 5'd0, 0), O_NONE};

        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, got);
            check($sformatf("vec%0d", i), {24'd0, got}, {24'd0, tbl[i].exp});
        end

        // Ten clean fetches: no stalls counted.
        do_reset();
        for (int i = 0; i < 10; i++) step(mk(1,0,0,0,0,0,0, 0, 0, 0, 0), got);
        check("clean_run_cnt", bus.stall_cnt, 32'd0);

        // Load waits three cycles, then completes with no fetch.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(mk(1,0,1,0,0,0,0, 0, 0, 0, 0), got);
            check("memwait_frozen", {24'd0, got}, {24'd0, O_NONE});
        end
        step(mk(0,1,1,0,0,0,0, 0, 0, 0, 0), got);
        check("memwait_release", {24'd0, got}, {24'd0, O_DONLY});
        check("memwait_cnt", bus.stall_cnt, 32'd4);

        // Halt is absorbing and freezes the counter.
        do_reset();
        step(mk(1,0,0,0,1,0,0, 0, 0, 0, 0), got);
        check("halt_entry", {24'd0, got}, {24'd0, O_HALT});
        c0 = 1;
        for (int i = 0; i < 5; i++) begin
            step(mk(logic'(i % 2), 1, 0, 0, 0, 1, 0, 0, 0, 0, 0), got);
            check("halt_outputs", {24'd0, got}, 32'd0);
            check("halt_sticky", {31'd0, bus.halt}, 32'd1);
            check("halt_cnt", bus.stall_cnt, c0);
        end

        // Redirect during an unhit store is deferred to the dhit cycle.
        do_reset();
        step(mk(1,0,0,1,0,1,0, 0, 0, 0, 0), got);
        check("pcsrc_deferred", {24'd0, got}, {24'd0, O_NONE});
        step(mk(1,1,0,1,0,1,0, 0, 0, 0, 0), got);
        check("pcsrc_on_dhit", {24'd0, got}, {24'd0, O_BRANCH});

        // Reset mid-wait returns to RUN asynchronously.
        step(mk(1,0,1,0,0,0,0, 0, 0, 0, 0), got);
        step(mk(1,0,1,0,0,0,0, 0, 0, 0, 0), got);
        do_reset();

        // Long wait drives the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) step(mk(1,0,1,0,0,0,0, 0, 0, 0, 0), got);
        check("sat_cnt4", {28'd0, bus4.stall_cnt}, 32'd15);
        check("sat_cnt32", bus.stall_cnt, 32'd20);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            s.ihit       = ($urandom_range(0, 3) != 0);
            s.dhit       = ($urandom_range(0, 1) != 0);
            s.dREN_m     = ($urandom_range(0, 9) == 0);
            s.dWEN_m     = ($urandom_range(0, 9) == 0);
            s.halt_m     = ($urandom_range(0, 49) == 0);
            s.pcsrc_m    = ($urandom_range(0, 9) == 0);
            s.memtoreg_e = ($urandom_range(0, 2) == 0);
            s.rd_e       = 5'($urandom_range(0, 3));
            s.rs_d       = 5'($urandom_range(0, 3));
            s.rt_d       = 5'($urandom_range(0, 3));
            s.uses_rt_d  = ($urandom_range(0, 1) != 0);
            step(s, got);
            if (m_halt && ($urandom_range(0, 3) == 0)) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipelined datapath. It generates enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC enable. It handles memory-stage waits on dhit, load-use hazards, control-transfer flushes resolved in MEM, and halt. It also keeps a saturating stall-cycle counter for performance checks.

Parameters:
REG_W, 5, register-index width
CNT_W, 32, stall counter width

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_m  in  1  EX/MEM latch holds a load (dREN_out)
dWEN_m  in  1  EX/MEM latch holds a store (dWEN_out)
halt_m  in  1  EX/MEM latch holds halt (halt_out)
pcsrc_m  in  1  taken branch/bne/jump/jr resolved in MEM
memtoreg_e  in  1  ID/EX latch holds a load
rd_e  in  REG_W  destination register of the ID/EX instruction
rs_d  in  REG_W  rs of the decode-stage instruction
rt_d  in  REG_W  rt of the decode-stage instruction
uses_rt_d  in  1  decode instruction reads rt
pc_en  out  1  PC update enable
en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  latch enables
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  synchronous bubble insert (take effect only when the same latch is enabled)
halt  out  1  sticky CPU halted
stall_cnt  out  CNT_W  cycles with pc_en low while not HALT

Behaviour:
- Clocking: one clock (CLK). Reset is asynchronous, active-low (nRST).
- State register: RUN, MEMWAIT, HALT. Reset -> RUN, stall_cnt=0, halt=0.
- While nRST is low, all enables and flushes are forced to 0.
- Outputs are Mealy: a function of the registered state and the current inputs.
- Definitions:
  - memreq = dREN_m | dWEN_m
  - loaduse = memtoreg_e & (rd_e!=0) & ((rd_e==rs_d) | (uses_rt_d & rd_e==rt_d))
- RUN:
  - memreq & !dhit -> all enables 0, pc_en 0; next state MEMWAIT.
  - Otherwise adv = ihit | (memreq & dhit), and all four latch enables = adv.
  - Priority when adv is high:
    - (1) halt_m: pc_en 0, flush_if_id, flush_id_ex, flush_ex_mem = 1; next state HALT.
    - (2) pcsrc_m: pc_en 1, flush_if_id = flush_id_ex = flush_ex_mem = 1 (three younger instructions squashed).
    - (3) loaduse: pc_en 0, en_if_id 0, flush_id_ex 1.
    - (4) adv with !ihit (dhit only): pc_en 0, flush_if_id 1.
    - (5) normal: pc_en 1, no flush.
  - adv low -> all enables 0, pc_en 0.
- MEMWAIT:
  - All enables 0, pc_en 0 until dhit.
  - On dhit, apply RUN rules (1)-(5) with adv=1 in the same cycle; next state RUN (or HALT).
  - The memory request is never re-issued: EX/MEM is frozen while waiting.
- HALT:
  - All enables 0, pc_en 0, flushes 0, halt=1.
  - Absorbing until nRST. halt goes high the cycle after entry.
- stall_cnt:
  - +1 on each clock edge with pc_en==0 while not in HALT and nRST high.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - pcsrc_m beats loaduse: the hazard instruction is squashed anyway.
  - dhit and ihit together advance normally.
  - pcsrc_m during an un-hit memreq is deferred until dhit.
- Reset mid-MEMWAIT or mid-HALT returns to RUN immediately (asynchronous), with counter cleared.

Test Plan:
- Reset then ihit=1, no hazards -> pc_en=1, all en=1, flushes 0, stall_cnt stays 0 over 10 cycles.
- dREN_m=1, dhit low 3 cycles, then dhit=1 with ihit=0 -> MEMWAIT 3 cycles with all en=0; on the dhit cycle en=1, pc_en=0, flush_if_id=1; stall_cnt=4.
- memtoreg_e=1, rd_e=8, rs_d=8, ihit=1 -> pc_en=0, en_if_id=0, flush_id_ex=1 for one cycle. Repeat with rd_e=0 -> no stall.
- pcsrc_m=1 and loaduse=1, ihit=1 -> pc_en=1, three flushes=1, en_if_id=1.
- halt_m=1, ihit=1 -> next cycle halt=1, all en 0. Then 5 cycles with ihit toggling -> outputs unchanged, stall_cnt unchanged.
- Assert nRST low while in MEMWAIT -> state RUN, stall_cnt=0, halt=0 without waiting for CLK. Preload the counter near max via a long wait -> verify saturation at 2^CNT_W-1 with a reduced CNT_W=4 build.
